code_lock_ctrl: RTL and testbench
=================================

# code_lock_ctrl

Parametrised digit-code lock controller: the next generation of the single-code keypad lock. It accepts keypad digits on `enter` strobes and compares a full CODE_LEN-digit sequence before deciding, so it never reveals which digit was wrong. It adds a timed auto-relock, a failed-attempt lockout, and an optionally re-programmable code. It sits between the keypad scanner/debouncer and the actuator driver.

## Interface
- DIGIT_W, 4, width of one keypad digit.
- CODE_LEN, 4, number of digits per code (≥1).
- MAX_TRIES, 3, consecutive wrong codes before lockout (≥1).
- UNLOCK_CYCLES, 500, cycles `unlocked` stays high (≥1).
- LOCKOUT_CYCLES, 1000, cycles of lockout (≥1).
- DEFAULT_CODE, {9,9,7,9}, reset code, CODE_LEN*DIGIT_W bits; first-entered digit in the MSBs.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- enter  in  1  single-cycle strobe: sample `digit`.
- digit  in  DIGIT_W  keypad value.
- clear  in  1  abandon the current entry, or relock when open.
- prog_en  in  1  qualifies `enter` as a code-programming digit while open.
- unlocked  out  1  registered; high only in OPEN.
- locked_out  out  1  registered; high only in LOCKOUT.
- fail_count  out  $clog2(MAX_TRIES+1)  consecutive wrong codes.
- progress  out  $clog2(CODE_LEN+1)  digits captured in the current entry or program sequence.

## Operation
- States: ENTRY, OPEN, LOCKOUT, PROG. Reset state is ENTRY.
- Reset values: unlocked=0, locked_out=0, fail_count=0, progress=0, mismatch flag=0, code register=DEFAULT_CODE.
- ENTRY, on each `enter`:
  - Compare `digit` with code digit[progress]; set the sticky mismatch flag on any difference; progress+1.
  - On the CODE_LEN-th digit with no mismatch: go to OPEN, fail_count←0.
  - On the CODE_LEN-th digit with a mismatch: fail_count+1. If the new value equals MAX_TRIES, go to LOCKOUT; otherwise stay in ENTRY.
  - In every case progress←0 and mismatch←0.
- ENTRY with `clear`: progress←0, mismatch←0, fail_count unchanged. This is not counted as an attempt.
- OPEN:
  - The timer loads UNLOCK_CYCLES on entry; on expiry, go to ENTRY.
  - `clear` returns to ENTRY immediately.
  - `enter` with prog_en=1 goes to PROG (configuration permitting) and is itself captured as digit 0.
  - `enter` with prog_en=0 is ignored.
- PROG:
  - Each `enter` shifts `digit` into a shadow register; progress+1.
  - On the CODE_LEN-th digit: the shadow is committed to the code register, then go to ENTRY with progress←0.
  - `clear` aborts to ENTRY and leaves the code register unchanged.
  - The unlock timer is frozen; unlocked=0 while in PROG.
- LOCKOUT:
  - The timer loads LOCKOUT_CYCLES; `enter`, `clear` and `prog_en` are ignored.
  - On expiry, go to ENTRY with fail_count←0.
- Simultaneous `clear` and `enter`: `clear` wins and the digit is discarded.
- Reset mid-operation forces all reset values, including restoring DEFAULT_CODE.

## Timing
- `digit` is sampled on the clock edge where `enter`=1. progress updates one cycle after that edge.
- Decision latency is 1 cycle: unlocked/locked_out/fail_count reflect the final digit on the cycle after its `enter` edge.
- unlocked is high for exactly UNLOCK_CYCLES cycles, unless `clear` or `enter`+prog_en ends OPEN early.
- locked_out is high for exactly LOCKOUT_CYCLES cycles.
- `enter` may be asserted on back-to-back cycles; every strobe is processed.
- Timer width is $clog2(max(UNLOCK_CYCLES, LOCKOUT_CYCLES)+1). progress never exceeds CODE_LEN−1 when observed in a stable state.

## Configuration
- CODE_LOCK_PROG_EN:
  - Defined: the PROG state and shadow register exist, and the code is programmable as described above.
  - Undefined: the code is fixed at DEFAULT_CODE, PROG is never entered, `prog_en` is ignored (the port remains), and `enter` in OPEN is ignored.

## Structure
- Package `code_lock_pkg`: the lock_state_t enum (ENTRY, OPEN, LOCKOUT, PROG) and the default-code constant helpers.
- Sub-module `lock_timer`: loadable down-counter with `load`, `load_val`, `run` and a one-cycle `expired` pulse. It is shared by OPEN and LOCKOUT.

## Test plan
- Default parameters, enter 9,9,7,9 -> unlocked=1 the cycle after the 4th strobe, for exactly 500 cycles, then 0; fail_count=0.
- Enter 9,1,7,9 -> unlocked stays 0, fail_count=1, progress=0. Repeat twice more -> locked_out=1 for 1000 cycles, with enters ignored throughout; then fail_count=0.
- Enter 9,9 then `clear`, then 9,9,7,9 -> unlocks; fail_count stays 0.
- `clear` and `enter` in the same cycle -> digit discarded, progress=0.
- With CODE_LOCK_PROG_EN: unlock, then prog_en + enter 1,2,3,4 -> ENTRY. Old code 9,9,7,9 now fails; 1,2,3,4 unlocks. Reset restores 9,9,7,9.
- Assert reset mid-entry and during LOCKOUT -> all outputs 0 on the next edge; the default code is accepted afterwards.

Source files
------------

// File: rtl/code_lock_pkg.sv
// Shared types and constants for the code lock: state encoding, the factory code
// and width helpers used by the controller and its timer.
package code_lock_pkg;

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2,
    PROG    = 2'd3
  } lock_state_t;

  // Factory code 9,9,7,9 for 4-bit digits; first-entered digit sits in the MSBs.
  localparam int         DEF_DIGIT_W  = 4;
  localparam int         DEF_CODE_LEN = 4;
  localparam logic [DEF_CODE_LEN*DEF_DIGIT_W-1:0] DEF_CODE = 16'h9979;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int timer_width(input int unlock_cycles, input int lockout_cycles);
    return $clog2(max_int(unlock_cycles, lockout_cycles) + 1);
  endfunction

endpackage

// File: rtl/code_lock_ctrl_if.sv
// Keypad-side bundle of the code lock: digit strobes in, lock status out.
// master = keypad/debouncer side, slave = lock controller.
interface code_lock_ctrl_if #(
  parameter int DIGIT_W = 4,
  parameter int FC_W    = 2,
  parameter int PR_W    = 3
);
  logic               enter;
  logic [DIGIT_W-1:0] digit;
  logic               clear;
  logic               prog_en;
  logic               unlocked;
  logic               locked_out;
  logic [FC_W-1:0]    fail_count;
  logic [PR_W-1:0]    progress;

  modport master (
    output enter, digit, clear, prog_en,
    input  unlocked, locked_out, fail_count, progress
  );

  modport slave (
    input  enter, digit, clear, prog_en,
    output unlocked, locked_out, fail_count, progress
  );
endinterface

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the OPEN and LOCKOUT dwell times.
// expired pulses for one cycle while running on the last count; load wins over run.
module lock_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         run,
  output logic         expired
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Firing on count 1 makes the owning state last exactly load_val cycles.
  assign expired = run && (r_cnt == W'(1));

endmodule

// File: rtl/code_lock_ctrl.sv
// Digit-code lock: full-sequence compare, timed relock and failed-attempt lockout.
// Code reprogramming while OPEN exists only when CODE_LOCK_PROG_EN is defined.
module code_lock_ctrl
  import code_lock_pkg::*;
#(
  parameter int DIGIT_W        = 4,
  parameter int CODE_LEN       = 4,
  parameter int MAX_TRIES      = 3,
  parameter int UNLOCK_CYCLES  = 500,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = DEF_CODE
) (
  input logic             clk,
  input logic             reset,
  code_lock_ctrl_if.slave bus
);

  localparam int CODE_W = CODE_LEN * DIGIT_W;
  localparam int FC_W   = $clog2(MAX_TRIES + 1);
  localparam int PR_W   = $clog2(CODE_LEN + 1);
  localparam int TMR_W  = timer_width(UNLOCK_CYCLES, LOCKOUT_CYCLES);
  localparam logic [PR_W-1:0] LAST = PR_W'(CODE_LEN - 1);

  lock_state_t         r_state, w_state_nxt;
  logic [PR_W-1:0]     r_progress, w_progress_nxt;
  logic                r_mismatch, w_mismatch_nxt;
  logic [FC_W-1:0]     r_fail, w_fail_nxt;
  logic                r_unlocked, r_locked_out;
  logic                w_unlocked_d, w_locked_out_d;
  logic                w_tmr_load, w_tmr_run, w_expired;
  logic [TMR_W-1:0]    w_tmr_val;
  logic [CODE_W-1:0]   w_code;
  logic [DIGIT_W-1:0]  w_exp_digit;
  logic                w_digit_ok;

`ifdef CODE_LOCK_PROG_EN
  logic [CODE_W-1:0]   r_code, w_code_nxt;
  logic [CODE_W-1:0]   r_shadow, w_shadow_nxt;
  logic [CODE_W-1:0]   w_shift;

  assign w_code  = r_code;
  assign w_shift = CODE_W'({r_shadow, bus.digit});
`else
  logic                w_unused;

  assign w_code   = DEFAULT_CODE;
  assign w_unused = bus.prog_en;
`endif

  // Code digit expected at the current position.
  always_comb begin
    w_exp_digit = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (r_progress == PR_W'(i)) w_exp_digit = w_code[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
    end
  end
  assign w_digit_ok = (bus.digit == w_exp_digit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ENTRY;
      r_progress   <= '0;
      r_mismatch   <= 1'b0;
      r_fail       <= '0;
      r_unlocked   <= 1'b0;
      r_locked_out <= 1'b0;
`ifdef CODE_LOCK_PROG_EN
      r_code       <= DEFAULT_CODE;
      r_shadow     <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_progress   <= w_progress_nxt;
      r_mismatch   <= w_mismatch_nxt;
      r_fail       <= w_fail_nxt;
      r_unlocked   <= w_unlocked_d;
      r_locked_out <= w_locked_out_d;
`ifdef CODE_LOCK_PROG_EN
      r_code       <= w_code_nxt;
      r_shadow     <= w_shadow_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_progress_nxt = r_progress;
    w_mismatch_nxt = r_mismatch;
    w_fail_nxt     = r_fail;
`ifdef CODE_LOCK_PROG_EN
    w_code_nxt     = r_code;
    w_shadow_nxt   = r_shadow;
`endif
    case (r_state)
      ENTRY: begin
        if (bus.clear) begin
          w_progress_nxt = '0;
          w_mismatch_nxt = 1'b0;
        end else if (bus.enter) begin
          if (r_progress == LAST) begin
            w_progress_nxt = '0;
            w_mismatch_nxt = 1'b0;
            if (!r_mismatch && w_digit_ok) begin
              w_state_nxt = OPEN;
              w_fail_nxt  = '0;
            end else begin
              w_fail_nxt = r_fail + 1'b1;
              if (w_fail_nxt == FC_W'(MAX_TRIES)) w_state_nxt = LOCKOUT;
            end
          end else begin
            w_progress_nxt = r_progress + 1'b1;
            w_mismatch_nxt = r_mismatch | !w_digit_ok;
          end
        end
      end
      OPEN: begin
        if (bus.clear) begin
          w_state_nxt = ENTRY;
`ifdef CODE_LOCK_PROG_EN
        end else if (bus.enter && bus.prog_en) begin
          // The strobe that leaves OPEN is already the first new digit.
          w_shadow_nxt = w_shift;
          if (r_progress == LAST) begin
            w_code_nxt     = w_shift;
            w_state_nxt    = ENTRY;
            w_progress_nxt = '0;
          end else begin
            w_state_nxt    = PROG;
            w_progress_nxt = r_progress + 1'b1;
          end
`endif
        end else if (w_expired) begin
          w_state_nxt = ENTRY;
        end
      end
      LOCKOUT: begin
        if (w_expired) begin
          w_state_nxt = ENTRY;
          w_fail_nxt  = '0;
        end
      end
      PROG: begin
`ifdef CODE_LOCK_PROG_EN
        if (bus.clear) begin
          w_state_nxt    = ENTRY;
          w_progress_nxt = '0;
        end else if (bus.enter) begin
          w_shadow_nxt = w_shift;
          if (r_progress == LAST) begin
            w_code_nxt     = w_shift;
            w_state_nxt    = ENTRY;
            w_progress_nxt = '0;
          end else begin
            w_progress_nxt = r_progress + 1'b1;
          end
        end
`else
        w_state_nxt    = ENTRY;
        w_progress_nxt = '0;
`endif
      end
      default: w_state_nxt = ENTRY;
    endcase
  end

  // Status is registered from the next state so it moves with the state register.
  always_comb begin
    w_unlocked_d   = (w_state_nxt == OPEN);
    w_locked_out_d = (w_state_nxt == LOCKOUT);
    w_tmr_load     = (w_state_nxt != r_state) && (w_unlocked_d || w_locked_out_d);
    w_tmr_val      = w_unlocked_d ? TMR_W'(UNLOCK_CYCLES) : TMR_W'(LOCKOUT_CYCLES);
    w_tmr_run      = (r_state == OPEN) || (r_state == LOCKOUT);
  end

  lock_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .run      (w_tmr_run),
    .expired  (w_expired)
  );

  assign bus.unlocked   = r_unlocked;
  assign bus.locked_out = r_locked_out;
  assign bus.fail_count = r_fail;
  assign bus.progress   = r_progress;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Bench for code_lock_ctrl: table of keypad vectors with expected status, plus
// dwell-time and reset sequences hooked onto selected vectors.
`timescale 1ns/1ps
module tb_code_lock_ctrl;
  import code_lock_pkg::*;

  localparam int DIGIT_W        = 4;
  localparam int CODE_LEN       = 4;
  localparam int MAX_TRIES      = 3;
  localparam int UNLOCK_CYCLES  = 500;
  localparam int LOCKOUT_CYCLES = 1000;
  localparam int FC_W           = $clog2(MAX_TRIES + 1);
  localparam int PR_W           = $clog2(CODE_LEN + 1);

  localparam int ACT_NONE = 0, ACT_UNL = 1, ACT_LO = 2, ACT_RST = 3;

  typedef struct packed {
    logic            unl;
    logic            lo;
    logic [FC_W-1:0] fc;
    logic [PR_W-1:0] pr;
  } out_t;

  typedef struct {
    logic               en;
    logic               cl;
    logic               pe;
    logic [DIGIT_W-1:0] d;
    out_t               exp;
    int                 act;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  code_lock_ctrl_if #(.DIGIT_W(DIGIT_W), .FC_W(FC_W), .PR_W(PR_W)) bus ();

  code_lock_ctrl #(
    .DIGIT_W        (DIGIT_W),
    .CODE_LEN       (CODE_LEN),
    .MAX_TRIES      (MAX_TRIES),
    .UNLOCK_CYCLES  (UNLOCK_CYCLES),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
    .DEFAULT_CODE   (16'h9979)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  vec_t tbl[$];
  out_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add(input bit en, input bit cl, input bit pe, input int d,
                              input bit unl, input bit lo, input int fc, input int pr,
                              input int act = ACT_NONE);
    vec_t v;
    v.en  = en;
    v.cl  = cl;
    v.pe  = pe;
    v.d   = DIGIT_W'(d);
    v.exp = '{unl: unl, lo: lo, fc: FC_W'(fc), pr: PR_W'(pr)};
    v.act = act;
    tbl.push_back(v);
  endfunction

  // Four entry digits; the first three only advance progress.
  function automatic void add_code(input int a, input int b, input int c, input int d,
                                   input int fc0, input bit unl, input bit lo, input int fc1,
                                   input int act = ACT_NONE);
    add(1, 0, 0, a, 0, 0, fc0, 1);
    add(1, 0, 0, b, 0, 0, fc0, 2);
    add(1, 0, 0, c, 0, 0, fc0, 3);
    add(1, 0, 0, d, unl, lo, fc1, 0, act);
  endfunction

  task automatic check(input out_t exp, input string name);
    out_t act;
    act = '{unl: bus.unlocked, lo: bus.locked_out, fc: bus.fail_count, pr: bus.progress};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got unl=%0b lo=%0b fc=%0d pr=%0d, want unl=%0b lo=%0b fc=%0d pr=%0d",
               name, act.unl, act.lo, act.fc, act.pr, exp.unl, exp.lo, exp.fc, exp.pr);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    bus.enter   = v.en;
    bus.clear   = v.cl;
    bus.prog_en = v.pe;
    bus.digit   = v.d;
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    bus.enter   = 1'b0;
    bus.clear   = 1'b0;
    bus.prog_en = 1'b0;
    if (exp_q.size() != 0) check(exp_q.pop_front(), name);
  endtask

  // Counts how long unlocked/locked_out stays high (current sample included) while
  // hammering enter with the default code, which must be ignored in both states.
  task automatic measure(input bit lo_sel, input int exp_len, input string name);
    int n;
    bit done;
    logic [DIGIT_W-1:0] code_d [CODE_LEN];
    code_d = '{4'd9, 4'd9, 4'd7, 4'd9};
    n = 1;
    done = 1'b0;
    for (int c = 0; c < 5000 && !done; c++) begin
      @(negedge clk);
      bus.enter = 1'b1;
      bus.digit = code_d[c % CODE_LEN];
      @(posedge clk);
      #1;
      bus.enter = 1'b0;
      if ((lo_sel ? bus.locked_out : bus.unlocked) === 1'b1) n++;
      else done = 1'b1;
    end
    n_vec++;
    if (n != exp_len) begin
      n_bad++;
      $display("FAIL %s: high for %0d cycles, want %0d", name, n, exp_len);
    end
  endtask

  task automatic reset_pulse(input string name);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check('0, {name, "_async"});
    @(posedge clk);
    #1;
    check('0, {name, "_edge"});
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.enter   = 1'b0;
    bus.clear   = 1'b0;
    bus.prog_en = 1'b0;
    bus.digit   = '0;

    add(0, 0, 0, 0, 0, 0, 0, 0);                       // reset state
    add_code(9, 9, 7, 9, 0, 1, 0, 0, ACT_UNL);         // default code opens
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add_code(9, 1, 7, 9, 0, 0, 0, 1);                  // wrong digit mid-code
    add(1, 0, 0, 9, 0, 0, 1, 1);
    add(1, 0, 0, 9, 0, 0, 1, 2);
    add(0, 1, 0, 0, 0, 0, 1, 0);                       // clear is not an attempt
    add(1, 1, 0, 7, 0, 0, 1, 0);                       // clear beats enter
    add_code(9, 9, 7, 9, 1, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);                       // clear relocks
    add(1, 0, 1, 5, 0, 0, 0, 1);                       // prog_en means nothing in ENTRY
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add_code(9, 1, 7, 9, 0, 0, 0, 1);
    add_code(0, 9, 7, 9, 1, 0, 0, 2);
    add_code(9, 9, 7, 8, 2, 0, 1, 3, ACT_LO);          // third failure locks out
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 9, 0, 0, 0, 1);
    add(1, 0, 0, 9, 0, 0, 0, 2, ACT_RST);              // reset mid-entry
    add_code(9, 9, 7, 9, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add_code(1, 1, 1, 1, 0, 0, 0, 1);
    add_code(2, 2, 2, 2, 1, 0, 0, 2);
    add_code(3, 3, 3, 3, 2, 0, 1, 3, ACT_RST);         // reset during lockout
    add_code(9, 9, 7, 9, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
`ifdef CODE_LOCK_PROG_EN
    add_code(9, 9, 7, 9, 0, 1, 0, 0);
    add(1, 0, 1, 1, 0, 0, 0, 1);                       // first program digit
    add(1, 0, 1, 2, 0, 0, 0, 2);
    add(1, 0, 0, 3, 0, 0, 0, 3);
    add(1, 0, 1, 4, 0, 0, 0, 0);                       // commit, back to ENTRY
    add_code(9, 9, 7, 9, 0, 0, 0, 1);                  // old code now wrong
    add_code(1, 2, 3, 4, 1, 1, 0, 0);
    add(1, 0, 1, 7, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0);                       // abort keeps 1,2,3,4
    add_code(1, 2, 3, 4, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, ACT_RST);
    add_code(1, 2, 3, 4, 0, 0, 0, 1);                  // reset restored default
    add_code(9, 9, 7, 9, 1, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
`else
    add_code(9, 9, 7, 9, 0, 1, 0, 0);
    add(1, 0, 1, 1, 1, 0, 0, 0);                       // no programming: stays open
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add_code(9, 9, 7, 9, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check('0, "reset_held");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
      case (tbl[i].act)
        ACT_UNL: begin
          measure(1'b0, UNLOCK_CYCLES, "unlock_len");
          check('0, "after_unlock");
        end
        ACT_LO: begin
          measure(1'b1, LOCKOUT_CYCLES, "lockout_len");
          check('0, "after_lockout");
        end
        ACT_RST: reset_pulse($sformatf("reset_vec%0d", i));
        default: ;
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
